bus_demux_ctrl: RTL
===================

Name: bus_demux_ctrl

Overview:
- Bus interface stage directly downstream of the 8085 core and upstream of the ROM/RAM/IO devices.
- Demultiplexes the AD bus into a registered 16-bit address using ALE.
- Decodes the high address byte into registered active-low chip selects.
- Classifies each machine cycle from S1/S0/IOMn and generates READY wait states per target region, replacing the free-running level latch in the system wrapper.

Parameters:
- RAM_PAGE, 8'h00, high-address page selecting RAM (ram_csn).
- ROM_PAGE, 8'h01, high-address page selecting ROM (rom_csn).
- RAM_WAIT, 0, wait states inserted for RAM accesses (0..15).
- ROM_WAIT, 1, wait states inserted for ROM accesses (0..15).
- IO_WAIT, 2, wait states inserted for any IO cycle (0..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ale  in  1  address latch enable from core.
- s0  in  1  status bit 0.
- s1  in  1  status bit 1.
- iomn  in  1  1 = IO cycle, 0 = memory cycle.
- rdn  in  1  read strobe, active low.
- wrn  in  1  write strobe, active low.
- haddress  in  8  high address byte.
- ad  in  8  multiplexed low address / data.
- address  out  16  latched address {haddress, ad}.
- ram_csn  out  1  RAM chip select, active low.
- rom_csn  out  1  ROM chip select, active low.
- io_csn  out  1  IO chip select, active low.
- ready  out  1  READY to core; 0 = insert wait state.
- cycle_type  out  3  current machine-cycle class.
- bus_error  out  1  one-cycle pulse on illegal or unmapped access.

Behaviour:
- Reset (async, rst=1) forces these outputs immediately:
  - address=16'h0000; all csn=1; ready=1; cycle_type=IDLE(0); bus_error=0; FSM=IDLE; wait counter=0.
- Address latch:
  - Each rising clk edge with ale=1 loads address <= {haddress, ad}.
  - With ale=0, address holds.
  - The value sampled on the last ale=1 edge is retained.
- cycle_type is captured on the same edges as address, from {iomn, s1, s0}:
  - 0 IDLE
  - 1 MEM_RD (0,1,0)
  - 2 MEM_WR (0,0,1)
  - 3 OP_FETCH (0,1,1)
  - 4 IO_RD (1,1,0)
  - 5 IO_WR (1,0,1)
  - 6 INTA (1,1,1)
  - 7 HALT (x,0,0)
- Decode targets:
  - iomn=1 -> IO.
  - Memory with haddress==RAM_PAGE -> RAM.
  - Memory with haddress==ROM_PAGE -> ROM.
  - Any other memory address -> UNMAPPED.
  - INTA and HALT select nothing.
- FSM states: IDLE, ADDR, ACCESS, WAIT, HOLD.
  - IDLE: ale=1 -> ADDR.
  - ADDR: ale=0 -> ACCESS. The decoded csn is asserted (0) from this edge, one clk after ALE falls.
  - ACCESS: strobe seen (rdn=0 xor wrn=0):
    - Load counter with the target's wait count.
    - Count != 0 -> WAIT, ready=0.
    - Count == 0 -> HOLD, ready stays 1.
  - WAIT: counter decrements each clk. At 1 -> HOLD and ready=1 on that edge. Exactly N low cycles for N wait states.
  - HOLD: rdn=1 and wrn=1 -> IDLE; csn deasserted and cycle_type=IDLE on that edge.
- Boundary conditions:
  - ale=1 in any non-IDLE state aborts the cycle: csn=1, ready=1, -> ADDR with the new address.
  - rdn=0 and wrn=0 together in ACCESS: bus_error pulse, no wait, all csn=1, -> HOLD.
  - UNMAPPED memory strobe: bus_error pulse, no csn, ready=1, -> HOLD.
  - Strobe released during WAIT: ready=1, csn=1, -> IDLE immediately.
  - HALT/INTA: no csn, ready=1; FSM returns to IDLE when ale next rises or strobes are idle.
  - At most one csn is low at any time.
  - rst asserted mid-cycle returns to reset values instantly; no bus_error is raised.

Optional Feature:
- Macro: WAIT_GEN_EN.
- Defined: wait-state generation as above.
- Undefined:
  - Counter logic omitted; ready tied to 1.
  - ACCESS goes directly to HOLD on a strobe.
  - All decode, chip-select and bus_error behaviour unchanged.

Decomposition:
- Package bus_pkg:
  - cycle_t enum (8 codes above).
  - state_t enum (IDLE..HOLD).
  - target_t enum (NONE, RAM, ROM, IO, UNMAPPED).
  - Default page constants.
- Sub-module bus_wait_counter: 4-bit loadable down-counter with load/value/expire, ready derived from a nonzero count; instantiated only under WAIT_GEN_EN.

Test Plan:
- ale=1 with haddress=8'h01, ad=8'h34, S1S0=11, iomn=0, then ale=0, rdn=0 for 3 clks -> address=16'h0134, cycle_type=3, rom_csn=0, ready low exactly 1 clk, rom_csn=1 one clk after rdn=1.
- Write to 16'h0080 (wrn=0, S1S0=01) -> ram_csn=0, ready never low, cycle_type=2, bus_error=0.
- IO read at port 8'h20 (iomn=1, S1S0=10) -> io_csn=0, ready low exactly 2 clks, cycle_type=4.
- Memory read at 16'h4000 -> no csn asserted, bus_error high exactly 1 clk at strobe, ready=1.
- ROM read with rst pulsed during WAIT -> all csn=1, ready=1, address=16'h0000 asynchronously.
- rdn=0 and wrn=0 together -> bus_error pulse, no csn. Then ale reasserted mid-HOLD -> new address latched, FSM restarts in ADDR.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and helpers for the 8085 bus interface stage.
// Holds the machine-cycle, FSM-state and decode-target enums, the default
// page/wait constants and the small decode functions used by bus_demux_ctrl.
package bus_pkg;

    typedef enum logic [2:0] {
        CYC_IDLE     = 3'd0,
        CYC_MEM_RD   = 3'd1,
        CYC_MEM_WR   = 3'd2,
        CYC_OP_FETCH = 3'd3,
        CYC_IO_RD    = 3'd4,
        CYC_IO_WR    = 3'd5,
        CYC_INTA     = 3'd6,
        CYC_HALT     = 3'd7
    } cycle_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        TGT_NONE     = 3'd0,
        TGT_RAM      = 3'd1,
        TGT_ROM      = 3'd2,
        TGT_IO       = 3'd3,
        TGT_UNMAPPED = 3'd4
    } target_t;

    localparam logic [7:0] DEFAULT_RAM_PAGE = 8'h00;
    localparam logic [7:0] DEFAULT_ROM_PAGE = 8'h01;
    localparam logic [3:0] DEFAULT_RAM_WAIT = 4'd0;
    localparam logic [3:0] DEFAULT_ROM_WAIT = 4'd1;
    localparam logic [3:0] DEFAULT_IO_WAIT  = 4'd2;

    // S1/S0 pick the transfer kind; IO/M splits memory from IO flavours.
    // S1=S0=0 is HALT regardless of IO/M.
    function automatic cycle_t classifyCycle(input logic iomn, input logic s1, input logic s0);
        cycle_t c;
        case ({s1, s0})
            2'b00:   c = CYC_HALT;
            2'b01:   c = iomn ? CYC_IO_WR : CYC_MEM_WR;
            2'b10:   c = iomn ? CYC_IO_RD : CYC_MEM_RD;
            default: c = iomn ? CYC_INTA  : CYC_OP_FETCH;
        endcase
        return c;
    endfunction

    // INTA, HALT and the idle class never select a device.
    function automatic target_t decodeTarget(input cycle_t cyc, input logic [7:0] page,
                                             input logic [7:0] ramPage, input logic [7:0] romPage);
        target_t t;
        case (cyc)
            CYC_IO_RD, CYC_IO_WR: t = TGT_IO;
            CYC_MEM_RD, CYC_MEM_WR, CYC_OP_FETCH: begin
                if (page == ramPage)      t = TGT_RAM;
                else if (page == romPage) t = TGT_ROM;
                else                      t = TGT_UNMAPPED;
            end
            default: t = TGT_NONE;
        endcase
        return t;
    endfunction

    // Chip-select vector ordering is {io, rom, ram}, active low.
    function automatic logic [2:0] chipSelectFor(input target_t t);
        logic [2:0] csn;
        case (t)
            TGT_RAM: csn = 3'b110;
            TGT_ROM: csn = 3'b101;
            TGT_IO:  csn = 3'b011;
            default: csn = 3'b111;
        endcase
        return csn;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// bus_wait_counter: 4-bit loadable down-counter pacing READY wait states.
// READY is high whenever the count is zero; expire flags the last wait cycle.
module bus_wait_counter
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic       dec_i,
    input  logic [3:0] value_i,
    output logic       expire_o,
    output logic       ready_o
);

    logic [3:0] count_q, count_d;

    // Clear beats load, load beats decrement; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 4'd0;
        end else if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Count register, cleared asynchronously so READY is high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == 4'd1);
    assign ready_o  = (count_q == 4'd0);

endmodule

// File: rtl/bus_demux_ctrl.sv
// bus_demux_ctrl: 8085 bus interface stage between the core and ROM/RAM/IO.
// Latches {haddress, ad} on ALE, classifies the machine cycle, drives
// registered active-low chip selects and flags illegal/unmapped accesses.
// Build option WAIT_GEN_EN: when defined, READY wait states are generated per
// target region; when undefined, READY is tied high and a strobe in ACCESS
// goes straight to HOLD.
module bus_demux_ctrl
    import bus_pkg::*;
#(
    parameter logic [7:0] RAM_PAGE = DEFAULT_RAM_PAGE,
    parameter logic [7:0] ROM_PAGE = DEFAULT_ROM_PAGE,
    parameter logic [3:0] RAM_WAIT = DEFAULT_RAM_WAIT,
    parameter logic [3:0] ROM_WAIT = DEFAULT_ROM_WAIT,
    parameter logic [3:0] IO_WAIT  = DEFAULT_IO_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ale,
    input  logic        s0,
    input  logic        s1,
    input  logic        iomn,
    input  logic        rdn,
    input  logic        wrn,
    input  logic [7:0]  haddress,
    input  logic [7:0]  ad,
    output logic [15:0] address,
    output logic        ram_csn,
    output logic        rom_csn,
    output logic        io_csn,
    output logic        ready,
    output logic [2:0]  cycle_type,
    output logic        bus_error
);

`ifdef WAIT_GEN_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [15:0] address_q, address_d;
    cycle_t      cycleType_q, cycleType_d;
    logic [2:0]  csn_q, csn_d;
    logic        busError_q, busError_d;

    target_t     target;
    logic        rdActive, wrActive, oneStrobe, bothStrobe, noStrobe, mapped;
    logic [3:0]  waitSel;
    logic        waitExpire;

    assign rdActive   = ~rdn;
    assign wrActive   = ~wrn;
    assign oneStrobe  = rdActive ^ wrActive;
    assign bothStrobe = rdActive & wrActive;
    assign noStrobe   = ~(rdActive | wrActive);

    assign target = decodeTarget(cycleType_q, address_q[15:8], RAM_PAGE, ROM_PAGE);
    assign mapped = (target == TGT_RAM) || (target == TGT_ROM) || (target == TGT_IO);

    // Wait-state budget of the region the latched cycle targets.
    always_comb begin
        case (target)
            TGT_RAM: waitSel = RAM_WAIT;
            TGT_ROM: waitSel = ROM_WAIT;
            TGT_IO:  waitSel = IO_WAIT;
            default: waitSel = 4'd0;
        endcase
    end

    // State and registered outputs; reset forces the idle bus picture at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            address_q   <= 16'h0000;
            cycleType_q <= CYC_IDLE;
            csn_q       <= 3'b111;
            busError_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            cycleType_q <= cycleType_d;
            csn_q       <= csn_d;
            busError_q  <= busError_d;
        end
    end

    // Next state: ALE always restarts the cycle in ADDR, aborting whatever was running.
    always_comb begin
        state_d = state_q;
        if (ale) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ADDR:   state_d = ST_ACCESS;
                ST_ACCESS: begin
                    if (bothStrobe) begin
                        state_d = ST_HOLD;
                    end else if (oneStrobe) begin
                        if (mapped && WAIT_EN && (waitSel != 4'd0)) state_d = ST_WAIT;
                        else                                        state_d = ST_HOLD;
                    end else if (target == TGT_NONE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (noStrobe)        state_d = ST_IDLE;
                    else if (waitExpire) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (noStrobe) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered bus outputs: latch, chip selects, error pulse.
    always_comb begin
        address_d   = address_q;
        cycleType_d = cycleType_q;
        csn_d       = csn_q;
        busError_d  = 1'b0;
        if (ale) begin
            address_d   = {haddress, ad};
            cycleType_d = classifyCycle(iomn, s1, s0);
            csn_d       = 3'b111;
        end else begin
            case (state_q)
                ST_ADDR: csn_d = chipSelectFor(target);
                ST_ACCESS: begin
                    if (bothStrobe) begin
                        busError_d = 1'b1;
                        csn_d      = 3'b111;
                    end else if (oneStrobe && (target == TGT_UNMAPPED)) begin
                        busError_d = 1'b1;
                    end else if (noStrobe && (target == TGT_NONE)) begin
                        cycleType_d = CYC_IDLE;
                    end
                end
                ST_WAIT, ST_HOLD: begin
                    if (noStrobe) begin
                        csn_d       = 3'b111;
                        cycleType_d = CYC_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WAIT_GEN_EN
    logic waitLoad, waitDec, waitClear;

    assign waitLoad  = ~ale && (state_q == ST_ACCESS) && oneStrobe && mapped;
    assign waitDec   = ~ale && (state_q == ST_WAIT) && ~noStrobe;
    assign waitClear = ale || ((state_q == ST_WAIT) && noStrobe);

    bus_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load_i   (waitLoad),
        .clear_i  (waitClear),
        .dec_i    (waitDec),
        .value_i  (waitSel),
        .expire_o (waitExpire),
        .ready_o  (ready)
    );
`else
    assign waitExpire = 1'b1;
    assign ready      = 1'b1;
`endif

    assign address    = address_q;
    assign ram_csn    = csn_q[0];
    assign rom_csn    = csn_q[1];
    assign io_csn     = csn_q[2];
    assign cycle_type = cycleType_q;
    assign bus_error  = busError_q;

endmodule
